// File: rtl/counter_sweep_ctrl_pkg.sv
// Shared definitions for the counter sweep sequencer: FSM state encoding and
// the direction codes that match the attached counter's mode input.
package counter_sweep_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DWELL,
        ST_STEP,
        ST_DONE
    } sweep_state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/sweep_dwell_timer.sv
// Dwell timer: loads the dwell length on entry to a dwell period, counts down
// while running, and flags the final dwell cycle.
module sweep_dwell_timer #(
    parameter int DWIDTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DWIDTH-1:0] load_val,
    input  logic              run,
    output logic              expire
);

    logic [DWIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (run && count != '0) begin
            count <= count - DWIDTH'(1);
        end
    end

    // A dwell of D cycles ends in the cycle where the loaded value has counted down to one.
    assign expire = (count == DWIDTH'(1));

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer driving an up/down counter: preload, then N single-cycle steps
// separated by D dwell cycles. Define SWEEP_PINGPONG_EN for a mirrored return leg.
module counter_sweep_ctrl
    import counter_sweep_ctrl_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DWIDTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  start_val,
    input  logic [WIDTH-1:0]  steps,
    input  logic [DWIDTH-1:0] dwell,
    input  logic              dir,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              leg,
    output logic              cnt_enable,
    output logic              cnt_preload,
    output logic [WIDTH-1:0]  cnt_preload_data,
    output logic              cnt_mode
);

    sweep_state_t      state_q, state_d;
    logic [WIDTH-1:0]  start_val_q;
    logic [WIDTH-1:0]  steps_q;
    logic [DWIDTH-1:0] dwell_q;
    logic              dir_q;
    logic [WIDTH-1:0]  rem_q;
    logic              leg_q;
    logic              aborted_q;
    logic              timer_load;
    logic              timer_expire;
    logic              last_step;
    logic              turn_leg;
    logic              abort_taken;

    assign last_step   = (rem_q == WIDTH'(1));
    assign abort_taken = abort && (state_q == ST_LOAD || state_q == ST_DWELL ||
                                   state_q == ST_STEP);

`ifdef SWEEP_PINGPONG_EN
    assign turn_leg = last_step && !leg_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leg_q <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            leg_q <= 1'b0;
        end else if (state_q == ST_STEP && !abort && turn_leg) begin
            leg_q <= 1'b1;
        end
    end
`else
    assign turn_leg = 1'b0;
    assign leg_q    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command registers only load from IDLE, so a start while busy cannot disturb them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_val_q <= '0;
            steps_q     <= '0;
            dwell_q     <= '0;
            dir_q       <= DIR_UP;
            rem_q       <= '0;
            aborted_q   <= 1'b0;
        end else begin
            aborted_q <= abort_taken;
            if (state_q == ST_IDLE && start) begin
                start_val_q <= start_val;
                steps_q     <= steps;
                dwell_q     <= dwell;
                dir_q       <= dir;
                rem_q       <= steps;
            end else if (state_q == ST_STEP && !abort) begin
                rem_q <= turn_leg ? steps_q : rem_q - WIDTH'(1);
            end
        end
    end

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (steps_q == '0) begin
                    state_d = ST_DONE;
                end else if (dwell_q == '0) begin
                    state_d = ST_STEP;
                end else begin
                    state_d    = ST_DWELL;
                    timer_load = 1'b1;
                end
            end
            ST_DWELL: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (timer_expire) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (last_step && !turn_leg) begin
                    state_d = ST_DONE;
                end else if (dwell_q == '0) begin
                    state_d = ST_STEP;
                end else begin
                    state_d    = ST_DWELL;
                    timer_load = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    sweep_dwell_timer #(
        .DWIDTH(DWIDTH)
    ) u_dwell_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (dwell_q),
        .run      (state_q == ST_DWELL),
        .expire   (timer_expire)
    );

    // Outputs decode registered state only; no input reaches an output combinationally.
    assign busy             = (state_q != ST_IDLE);
    assign done             = (state_q == ST_DONE);
    assign aborted          = aborted_q;
    assign leg              = leg_q;
    assign cnt_enable       = (state_q == ST_LOAD) || (state_q == ST_STEP);
    assign cnt_preload      = (state_q == ST_LOAD);
    assign cnt_preload_data = start_val_q;
    assign cnt_mode         = (state_q == ST_STEP) ? (dir_q ^ leg_q) : DIR_UP;

endmodule
